// File: rtl/divider_cmd_ctrl_if.sv
// Command and response valid/ready channels between a requester and divider_cmd_ctrl.
// The master side issues commands and sinks response beats; the slave side is the controller.
interface divider_cmd_ctrl_if #(
  parameter int unsigned DATA_W = 64
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2*DATA_W+15:0]   cmd_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W+7:0]      rsp_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/divider_cmd_ctrl.sv
// Command/response front end for the iterative divider core: sizes operands, runs the core, returns tagged beats.
// Define DIVIDER_CMD_STATS_EN to add saturating stat_ok/stat_err completion counters.
module divider_cmd_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter bit          SIGNED  = 1'b0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 divider_clk,
  input  logic                 reset_n,
  divider_cmd_ctrl_if.slave    bus,
  output logic                 core_reset_n,
  output logic                 core_start,
  output logic [DATA_W-1:0]    core_num,
  output logic [DATA_W-1:0]    core_den,
  input  logic                 core_done,
  input  logic [DATA_W-1:0]    core_quo,
  input  logic [DATA_W-1:0]    core_rem
`ifdef DIVIDER_CMD_STATS_EN
  ,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_err
`endif
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RSP_W = DATA_W + 8;

  localparam logic [7:0] TAG_QUO      = 8'h0A;
  localparam logic [7:0] TAG_REM      = 8'h0B;
  localparam logic [7:0] TAG_TIMEOUT  = 8'hED;
  localparam logic [7:0] TAG_BAD_CODE = 8'hEE;
  localparam logic [7:0] TAG_DIV_ZERO = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_SEND_Q,
    ST_SEND_R,
    ST_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]    rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                core_reset_n_d;
  logic                core_start_d;
  logic [DATA_W-1:0]   num_d, den_d;

  logic [7:0]          code;
  logic [DATA_W-1:0]   num_raw, den_raw;
  logic [DATA_W-1:0]   num_ext, den_ext;
  logic                code_ok;
  logic                unused_rsvd;

  assign code        = bus.cmd_data[2*DATA_W+7 -: 8];
  assign num_raw     = bus.cmd_data[2*DATA_W-1 -: DATA_W];
  assign den_raw     = bus.cmd_data[DATA_W-1:0];
  assign unused_rsvd = ^bus.cmd_data[2*DATA_W+15 -: 8];

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Keep the low 8k bits and fill above them with zero or the sign bit at 8k-1.
  function automatic logic [DATA_W-1:0] extend_op(input logic [DATA_W-1:0] v, input logic [7:0] k);
    logic [DATA_W-1:0] r;
    logic              s;
    int unsigned       w;
    w = 32'(k) << 3;
    s = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (32'(k) == b + 1) s = v[8*b+7];
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = (i < w) ? v[i] : (SIGNED & s);
    end
    return r;
  endfunction

  assign num_ext = extend_op(num_raw, code);
  assign den_ext = extend_op(den_raw, code);
  assign code_ok = (code != 8'd0) && (32'(code) <= NB);

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    core_reset_n_d = core_reset_n;
    core_start_d   = 1'b0;
    num_d          = core_num;
    den_d          = core_den;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d    = 1'b1;
        core_reset_n_d = 1'b1;
        rsp_valid_d    = 1'b0;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          num_d       = num_ext;
          den_d       = den_ext;
          if (!code_ok) begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {TAG_BAD_CODE, {DATA_W{1'b0}}};
          end else if (den_ext == '0) begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {TAG_DIV_ZERO, {DATA_W{1'b0}}};
          end else begin
            state_d        = ST_CLEAR;
            core_reset_n_d = 1'b0;
          end
        end
      end

      ST_CLEAR: begin
        state_d        = ST_START;
        core_reset_n_d = 1'b1;
        core_start_d   = 1'b1;
      end

      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      // A done seen on the timeout cycle still yields a normal result.
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          state_d     = ST_SEND_Q;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {TAG_QUO, core_quo};
          rem_d       = core_rem;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d     = ST_ERR;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {TAG_TIMEOUT, {DATA_W{1'b0}}};
        end
      end

      ST_SEND_Q: begin
        if (bus.rsp_ready) begin
          state_d    = ST_SEND_R;
          rsp_data_d = {TAG_REM, rem_q};
        end
      end

      ST_SEND_R, ST_ERR: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge divider_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      core_reset_n <= 1'b0;
      core_start   <= 1'b0;
      core_num     <= '0;
      core_den     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      core_reset_n <= core_reset_n_d;
      core_start   <= core_start_d;
      core_num     <= num_d;
      core_den     <= den_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef DIVIDER_CMD_STATS_EN
  logic ok_evt, err_evt;

  assign ok_evt  = (state_q == ST_SEND_R) && bus.rsp_ready;
  assign err_evt = (state_q == ST_ERR) && bus.rsp_ready;

  // Saturating completion counters.
  always_ff @(posedge divider_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else begin
      if (ok_evt && (stat_ok != 16'hFFFF))   stat_ok  <= stat_ok + 16'd1;
      if (err_evt && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_divider_cmd_ctrl.sv
// Directed bench for divider_cmd_ctrl: unsigned DUT with a small core model, plus a signed DUT for extension.
module tb_divider_cmd_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 20;

  logic divider_clk = 1'b0;
  logic reset_n     = 1'b0;
  always #5 divider_clk = ~divider_clk;

  divider_cmd_ctrl_if #(.DATA_W(DW)) bus ();
  divider_cmd_ctrl_if #(.DATA_W(DW)) bus_s ();

  logic          core_reset_n, core_start, core_done;
  logic [DW-1:0] core_num, core_den, core_quo, core_rem;
  logic          core_reset_n_s, core_start_s;
  logic [DW-1:0] core_num_s, core_den_s;
`ifdef DIVIDER_CMD_STATS_EN
  logic [15:0]   stat_ok, stat_err, stat_ok_s, stat_err_s;
  logic [15:0]   se0;
`endif

  divider_cmd_ctrl #(.DATA_W(DW), .SIGNED(1'b0), .TIMEOUT(TO)) u_dut (
    .divider_clk (divider_clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .core_reset_n(core_reset_n),
    .core_start  (core_start),
    .core_num    (core_num),
    .core_den    (core_den),
    .core_done   (core_done),
    .core_quo    (core_quo),
    .core_rem    (core_rem)
`ifdef DIVIDER_CMD_STATS_EN
    ,
    .stat_ok     (stat_ok),
    .stat_err    (stat_err)
`endif
  );

  divider_cmd_ctrl #(.DATA_W(DW), .SIGNED(1'b1), .TIMEOUT(TO)) u_dut_s (
    .divider_clk (divider_clk),
    .reset_n     (reset_n),
    .bus         (bus_s),
    .core_reset_n(core_reset_n_s),
    .core_start  (core_start_s),
    .core_num    (core_num_s),
    .core_den    (core_den_s),
    .core_done   (1'b0),
    .core_quo    ({DW{1'b0}}),
    .core_rem    ({DW{1'b0}})
`ifdef DIVIDER_CMD_STATS_EN
    ,
    .stat_ok     (stat_ok_s),
    .stat_err    (stat_err_s)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  int          model_lat = 10;
  bit          model_en  = 1'b1;
  logic [63:0] m_quo = '0;
  logic [63:0] m_rem = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge divider_clk) cyc++;

  // start_cyc is the edge on which the core samples the start pulse.
  always @(negedge divider_clk) begin
    if (core_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc + 1;
    end
  end

  // Core model: raises done model_lat cycles after the edge that samples start.
  initial begin
    core_done = 1'b0;
    core_quo  = '0;
    core_rem  = '0;
    forever begin
      @(negedge divider_clk);
      if (core_start === 1'b1 && model_en) begin
        repeat (model_lat + 1) @(posedge divider_clk);
        #1;
        core_done = 1'b1;
        core_quo  = m_quo;
        core_rem  = m_rem;
        @(posedge divider_clk);
        #1 core_done = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] k, input logic [63:0] num, input logic [63:0] den,
                          output int acc_cyc);
    int i;
    i = 0;
    @(negedge divider_clk);
    while (!bus.cmd_ready && i < 100) begin
      @(negedge divider_clk);
      i++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_data  = {8'h5A, k, num, den};
    bus.cmd_valid = 1'b1;
    @(posedge divider_clk);
    #1 bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic get_beat(output logic [71:0] d, output int seen);
    int i;
    i = 0;
    @(negedge divider_clk);
    while (!bus.rsp_valid && i < 200) begin
      @(negedge divider_clk);
      i++;
    end
    check("rsp_wait", bus.rsp_valid, 1'b1);
    d    = bus.rsp_data;
    seen = cyc;
    bus.rsp_ready = 1'b1;
    @(posedge divider_clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [71:0] d;
    int          acc, seen, st0, stray;
    logic [7:0]  bad_codes [2];
    bad_codes[0] = 8'd0;
    bad_codes[1] = 8'd9;

    bus.cmd_valid   = 1'b0;
    bus.cmd_data    = '0;
    bus.rsp_ready   = 1'b0;
    bus_s.cmd_valid = 1'b0;
    bus_s.cmd_data  = '0;
    bus_s.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge divider_clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_core_reset_n", core_reset_n, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_num", core_num, 64'd0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 72'd0);
    reset_n = 1'b1;
    @(negedge divider_clk);
    check("idle_core_reset_n", core_reset_n, 1'b1);

    // 200/7 on one byte, upper field bits are junk
    m_quo = 64'd28; m_rem = 64'd4; model_lat = 10;
    st0 = start_cnt;
    send_cmd(8'd1, 64'hDEAD_BEEF_0000_12C8, 64'h1234_5678_9ABC_DE07, acc);
    check("t1_core_num", core_num, 64'd200);
    check("t1_core_den", core_den, 64'd7);
    check("t1_clear", core_reset_n, 1'b0);
    check("t1_cmd_ready_low", bus.cmd_ready, 1'b0);
    get_beat(d, seen);
    check("t1_latency", seen - acc, 13);
    check("t1_quo_beat", d, {8'h0A, 64'd28});
    get_beat(d, seen);
    check("t1_rem_beat", d, {8'h0B, 64'd4});
    check("t1_ready_after", bus.cmd_ready, 1'b1);
    check("t1_one_start", start_cnt - st0, 1);

    // Two-byte operand, zero-extended here and sign-extended on the signed instance
    m_quo = 64'd9348; m_rem = 64'd0; model_lat = 2;
    send_cmd(8'd2, 64'h1234_5678_9ABC_FF9C, 64'h0000_0000_0000_0007, acc);
    check("t2_unsigned_num", core_num, 64'h0000_0000_0000_FF9C);
    check("t2_unsigned_den", core_den, 64'd7);
    get_beat(d, seen);
    check("t2_quo_beat", d, {8'h0A, 64'd9348});
    get_beat(d, seen);
    check("t2_rem_beat", d, {8'h0B, 64'd0});
    @(negedge divider_clk);
    bus_s.cmd_data  = {8'h00, 8'd2, 64'h1234_5678_9ABC_FF9C, 64'h0000_0000_0000_0007};
    bus_s.cmd_valid = 1'b1;
    @(posedge divider_clk);
    #1 bus_s.cmd_valid = 1'b0;
    check("t2_signed_num", core_num_s, 64'hFFFF_FFFF_FFFF_FF9C);
    check("t2_signed_den", core_den_s, 64'd7);

    // Invalid size codes, then a denominator that is zero in its low 32 bits
    st0 = start_cnt;
    for (int j = 0; j < 2; j++) begin
      send_cmd(bad_codes[j], 64'd5, 64'd3, acc);
      check("t3_code_err_immediate", bus.rsp_valid, 1'b1);
      get_beat(d, seen);
      check("t3_code_err_beat", d, {8'hEE, 64'd0});
    end
`ifdef DIVIDER_CMD_STATS_EN
    se0 = stat_err;
`endif
    send_cmd(8'd4, 64'hFFFF_FFFF_0000_0010, 64'h1111_2222_0000_0000, acc);
    check("t3_div0_immediate", bus.rsp_valid, 1'b1);
    get_beat(d, seen);
    check("t3_div0_beat", d, {8'hEF, 64'd0});
    check("t3_no_start", start_cnt - st0, 0);
`ifdef DIVIDER_CMD_STATS_EN
    check("t3_stat_err", stat_err, se0 + 16'd1);
`endif

    // Core never answers: timeout beat 20 cycles after start is sampled
    model_en = 1'b0;
    send_cmd(8'd1, 64'd10, 64'd3, acc);
    get_beat(d, seen);
    check("t4_timeout_beat", d, {8'hED, 64'd0});
    check("t4_timeout_cycles", seen - start_cyc, 20);

    // Done on the very cycle the counter hits the limit wins over timeout
    model_en = 1'b1; model_lat = 19; m_quo = 64'd77; m_rem = 64'd1;
    send_cmd(8'd1, 64'd155, 64'd2, acc);
    get_beat(d, seen);
    check("t4_done_wins_quo", d, {8'h0A, 64'd77});
    get_beat(d, seen);
    check("t4_done_wins_rem", d, {8'h0B, 64'd1});

    // Reset while the quotient beat is stalled
    model_lat = 3; m_quo = 64'd5; m_rem = 64'd2;
    send_cmd(8'd8, 64'd100, 64'd20, acc);
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge divider_clk);
    check("t5_quo_valid", bus.rsp_valid, 1'b1);
    check("t5_quo_beat", bus.rsp_data, {8'h0A, 64'd5});
    repeat (5) @(negedge divider_clk);
    check("t5_hold_valid", bus.rsp_valid, 1'b1);
    check("t5_hold_data", bus.rsp_data, {8'h0A, 64'd5});
    reset_n = 1'b0;
    #1;
    check("t5_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("t5_rst_core_reset_n", core_reset_n, 1'b0);
    @(negedge divider_clk);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge divider_clk);
    check("t5_cmd_ready_after", bus.cmd_ready, 1'b1);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge divider_clk);
      if (bus.rsp_valid) stray++;
    end
    check("t5_no_stray_beat", stray, 0);
`ifdef DIVIDER_CMD_STATS_EN
    check("t5_stat_ok_cleared", stat_ok, 16'd0);
`endif
    bus.rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
